seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Run controller for a programmable serial pattern detector. It generalises the fixed-pattern Moore detector to a software-loaded PAT_W-bit pattern.
- Software issues start/stop and configuration; the block arms history capture, gates the serial stream with in_valid and counts matches.
- Signals completion when a match threshold is reached.
- Sits between the control/register interface and the raw serial input bit.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of match counter and threshold

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  one-cycle request to begin a run; ignored unless IDLE
stop  input  1  abort request; honoured in ARM and RUN
cfg_pattern  input  PAT_W  pattern to detect, MSB = first bit received; latched on accepted start
cfg_overlap  input  1  1 = overlapping matches allowed; latched on accepted start
cfg_threshold  input  CNT_W  match count ending the run; 0 = run until stop; latched on accepted start
in_valid  input  1  qualifies in for this cycle
in  input  1  serial data bit
busy  output  1  high in ARM and RUN
match  output  1  one-cycle pulse per detected pattern
match_count  output  CNT_W  matches in current/last run
done  output  1  one-cycle pulse when threshold reached

Behaviour:
- Reset (rst low at a clk edge): state=IDLE, busy=0, match=0, done=0, match_count=0, history=0, fill=0, latched config=0.
- FSM states: IDLE, ARM, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 latches config, clears match_count, history and fill, then goes to ARM.
  - stop has no effect.
- ARM: one cycle. in/in_valid are ignored. Goes to RUN, or to IDLE if stop=1.
- RUN, on an edge with in_valid=1:
  - hist_next = {history[PAT_W-2:0], in}.
  - fill_next = min(fill+1, PAT_W).
  - Hit when fill_next==PAT_W and hist_next==pattern.
  - On a hit: match=1 on the following cycle; match_count increments at that same edge, saturating at 2^CNT_W-1.
  - On a hit with overlap=0: fill resets to 0 (history still shifts).
  - On a hit with overlap=1: fill stays at PAT_W.
- Latency: bit sampled at edge k gives match high from edge k to edge k+1.
- in_valid=0 in RUN: no shift, no match; history and fill hold.
- Threshold reached: when the incremented count equals a nonzero threshold, go to DONE. done pulses for one cycle coincident with that final match pulse. DONE goes to IDLE on the next edge, with busy=0 from DONE onward.
- stop=1 in RUN: go to IDLE next edge. The bit presented that cycle is discarded (no shift, no match, no count). Stop has priority over a simultaneous hit.
- start while busy or in DONE: ignored; config is not re-latched.
- match_count holds its value in IDLE until the next accepted start.
- Config inputs are sampled only on an accepted start; later changes have no effect on the current run.
- rst low mid-run: immediate return to reset values on that edge. No done or match pulse.

Decomposition:
- Shared package seq_detect_pkg holds:
  - state encoding localparams: IDLE=2'b00, ARM=2'b01, RUN=2'b10, DONE=2'b11
  - default PAT_W/CNT_W constants
- One sub-module, seq_shift_match:
  - holds the history shift register, fill counter and comparator
  - inputs: clk, rst, clr, shift_en, in, pattern, overlap
  - output: hit (combinational, from hist_next/fill_next)
- The top holds the FSM, config latches, counter and output registers.

Test Plan:
- Pattern 1001, overlap=1, threshold=0; stream 1,0,0,1,0,0,1 with in_valid=1 -> match pulses after bits 4 and 7; match_count=2; busy stays 1; done never.
- Same stream, overlap=0 -> single match after bit 4, none after bit 7; match_count=1.
- Pattern 1001, threshold=2, overlap=1, same stream -> done and match pulse together after bit 7; next cycle IDLE, busy=0, match_count=2 held.
- Pattern 1001, overlap=1, threshold=0; stream 1,0,0,1 with in_valid=0 inserted between every bit and in toggled during gaps -> exactly one match, after the 4th valid bit.
- Stop asserted in the same cycle as the final '1' of 1001 -> no match, count unchanged, IDLE next cycle. A start pulse during RUN -> ignored, config unchanged.
- rst low during RUN with fill=3 -> all outputs 0. A new start with 001 then 1 -> no spurious match from stale history.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   state_e          : run-controller state encoding
//   PAT_W_DEF        : default pattern length in bits
//   CNT_W_DEF        : default match counter / threshold width
package seq_detect_pkg;

    localparam int unsigned PAT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/seq_shift_match.sv
// History shift register, fill counter and pattern comparator.
//   clk, rst   : clock, synchronous active-low reset
//   clr        : clear history and fill (new run)
//   shift_en   : accept 'in' this cycle
//   in         : serial data bit
//   pattern    : pattern to detect, MSB = oldest bit
//   overlap    : 1 = keep fill full after a hit
//   hit        : combinational; the bit being shifted in completes a match
module seq_shift_match #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_next;
    logic [FILL_W-1:0] fill_q, fill_d, fill_next;

    // Candidate values as if the bit were accepted; hit only counts when it is.
    always_comb begin
        hist_next = {hist_q[PAT_W-2:0], in};
        fill_next = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        hit       = shift_en && (fill_next == FILL_W'(PAT_W)) && (hist_next == pattern);
    end

    // Next-state: non-overlapping mode restarts the fill after a hit.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = hist_next;
            fill_d = (hit && !overlap) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector.
//   clk, rst        : clock, synchronous active-low reset
//   start, stop     : run request (IDLE only) / abort (ARM, RUN)
//   cfg_pattern     : pattern, MSB first received; latched on accepted start
//   cfg_overlap     : overlapping matches allowed; latched on accepted start
//   cfg_threshold   : match count ending the run, 0 = until stop
//   in_valid, in    : qualified serial input bit
//   busy            : high in ARM and RUN
//   match           : one-cycle pulse per detected pattern
//   match_count     : matches in current/last run (saturating)
//   done            : one-cycle pulse with the match that reaches threshold
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_threshold,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             match_q, match_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] thr_q, thr_d;

    logic             clr_c;
    logic             shift_en_c;
    logic             hit;
    logic [CNT_W-1:0] count_inc;

    // Stop wins over the bit presented in the same cycle, so it blocks the shift.
    assign clr_c      = (state_q == IDLE) && start;
    assign shift_en_c = (state_q == RUN) && in_valid && !stop;
    assign count_inc  = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    seq_shift_match #(
        .PAT_W (PAT_W)
    ) u_shift_match (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_c),
        .shift_en (shift_en_c),
        .in       (in),
        .pattern  (pat_q),
        .overlap  (ovl_q),
        .hit      (hit)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        match_d = 1'b0;
        done_d  = 1'b0;
        count_d = count_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        thr_d   = thr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = cfg_pattern;
                    ovl_d   = cfg_overlap;
                    thr_d   = cfg_threshold;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (hit) begin
                        match_d = 1'b1;
                        count_d = count_inc;
                        if ((thr_q != '0) && (count_inc == thr_q)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            match_q <= match_d;
            done_q  <= done_d;
            count_q <= count_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            thr_q   <= thr_d;
        end
    end

    assign busy        = busy_q;
    assign match       = match_q;
    assign done        = done_q;
    assign match_count = count_q;

endmodule
